rename_table_ckpt: RTL and testbench
====================================

# rename_table_ckpt

Speculative register alias table with branch checkpoints. It sits between decode/rename and the reorder buffer. It replaces the flush-on-mispredict rename table: each issued branch saves a snapshot of the speculative mapping, so a mispredict restores rename state in one cycle instead of draining the pipeline. Availability comes from a per-tag ready scoreboard, so restored mappings report correct readiness.

## Interface
Parameters:
- NUM_LOOKUP, 4, source-operand lookup ports (2 per issue slot)
- NUM_ISSUE, 2, rename/issue slots per cycle
- NUM_COMMIT, 2, commit ports
- NUM_WB, 4, writeback ports
- NUM_REGS, 32, architectural registers; register 0 is hardwired and never renamed
- ID_SIZE, $clog2(NUM_REGS), architectural register index width
- TAG_SIZE, 7, physical tag width
- NUM_CKPT, 4, checkpoint slots (power of two)
- CKPT_ID, $clog2(NUM_CKPT), checkpoint index width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- IN_lookupIDs  in  NUM_LOOKUP×ID_SIZE  source register IDs
- OUT_lookupAvail  out  NUM_LOOKUP×1  operand ready
- OUT_lookupSpecTag  out  NUM_LOOKUP×TAG_SIZE  current speculative tag
- IN_issueValid / IN_issueIDs / IN_issueTags  in  NUM_ISSUE×(1/ID_SIZE/TAG_SIZE)  destination renames
- IN_ckptSave  in  1  save a snapshot that includes this cycle's issues
- OUT_ckptID  out  CKPT_ID  slot that the next save will take (the tail)
- OUT_ckptFull  out  1  no free slot
- IN_ckptRelease  in  1  oldest checkpoint's branch resolved correctly; free it
- IN_mispred  in  1  recovery request
- IN_mispredCkptValid  in  1  1: restore from IN_mispredCkpt; 0: restore from committed state
- IN_mispredCkpt  in  CKPT_ID  checkpoint to restore
- IN_commitValid / IN_commitIDs / IN_commitTags  in  NUM_COMMIT×(1/ID_SIZE/TAG_SIZE)
- OUT_commitPrevTags  out  NUM_COMMIT×TAG_SIZE  previous committed tag of IN_commitIDs[i], for freeing
- IN_wbValid / IN_wbTag  in  NUM_WB×(1/TAG_SIZE)  results produced

## Operation
State:
- per register: comTag, specTag
- ready[2^TAG_SIZE]
- NUM_CKPT×NUM_REGS specTag snapshots
- head and tail pointers, each CKPT_ID wide
- count, CKPT_ID+1 wide

Lookup (combinational), for each port i:
- OUT_lookupSpecTag = specTag[ID]; OUT_lookupAvail = ready[specTag].
- Writeback bypass: if any IN_wbValid has a tag equal to OUT_lookupSpecTag, avail = 1.
- Same-group issue bypass: for j < i/2, if issue j is valid, has the same ID and ID ≠ 0, then tag = IN_issueTags[j] and avail = 0. The highest such j wins.

Sequential updates:
- Issue: for each valid slot with ID ≠ 0, specTag[ID] ← tag and ready[tag] ← 0. If two slots write the same ID, the higher slot wins.
- Writeback: ready[tag] ← 1. Writeback wins over an issue clear of the same tag in the same cycle (illegal from the free list; flag with an assertion).
- Save: when IN_ckptSave and !OUT_ckptFull, snapshot[tail] ← specTag with this cycle's issues applied; tail++ and count++. A save while full is dropped, and an assertion fires.
- Release: when IN_ckptRelease and count ≠ 0, head++ and count--. A release while empty is ignored.
- Commit: comTag[ID] ← tag, with the highest port winning. OUT_commitPrevTags reads comTag before this cycle's update.

Recovery (IN_mispred):
- Issue and save are suppressed. Writeback and commit still apply.
- If IN_mispredCkptValid: specTag ← snapshot[IN_mispredCkpt]. tail ← IN_mispredCkpt, which frees that slot and every younger one. count ← (IN_mispredCkpt − head') mod NUM_CKPT, where head' is head after any same-cycle release. Releasing the same slot being restored is illegal.
- Else: specTag ← comTag, with same-cycle commits overriding. head = tail and count = 0.
- ready is not altered by recovery. Tags of squashed ops stay 0 until the free list reissues them and writeback sets them.

## Timing
- Lookup and OUT_commitPrevTags: zero-latency combinational.
- All updates are visible to lookups in the next cycle.
- OUT_ckptFull = (count == NUM_CKPT). OUT_ckptID = tail. Both are registered-state derived, so decode must stall a branch in the same cycle that it sees full.
- Pointers wrap modulo NUM_CKPT. At count == NUM_CKPT, head == tail, and count disambiguates full from empty.
- Save and release in the same cycle when full: the release frees a slot first, so the save is accepted and count is unchanged.
- Reset state (asynchronous, immediate):
  - specTag[i] = comTag[i] = i; all ready = 1
  - head = tail = count = 0
  - outputs: OUT_ckptFull = 0, OUT_ckptID = 0; lookups return tag = ID with avail = 1
  - reset mid-recovery discards all checkpoints.

## Test plan
- Reset, then look up r5 → tag 5, avail 1; OUT_ckptID 0, OUT_ckptFull 0.
- Issue r3→tag 40 in slot 0 with lookup port 2 on r3 in the same cycle → port 2 shows tag 40, avail 0. Next cycle, wb tag 40 → avail 1 through the bypass that cycle, and from ready after.
- Issue r3→40 plus save (ckpt 0), then r3→41, then mispred ckpt 0 → lookup r3 = 40; tail 0, count 0; ready[41] stays 0.
- Four saves → OUT_ckptFull 1; a fifth save is dropped. Release plus save in the same cycle → full stays 1, head 1, tail 1.
- Commit r7→50 during a mispred with IN_mispredCkptValid = 0 → r7 specTag 50; OUT_commitPrevTags = 7; count 0.
- Assert rst during a recovery with 3 live checkpoints → count 0 and all mappings identity immediately, before the next clk edge.

Source files
------------

// File: rtl/rename_table_ckpt.sv
// Speculative register alias table with per-branch specTag snapshots for single-cycle
// mispredict recovery, plus a per-tag ready scoreboard feeding operand availability.
module rename_table_ckpt #(
  parameter int unsigned NUM_LOOKUP = 4,
  parameter int unsigned NUM_ISSUE  = 2,
  parameter int unsigned NUM_COMMIT = 2,
  parameter int unsigned NUM_WB     = 4,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned ID_SIZE    = $clog2(NUM_REGS),
  parameter int unsigned TAG_SIZE   = 7,
  parameter int unsigned NUM_CKPT   = 4,
  parameter int unsigned CKPT_ID    = $clog2(NUM_CKPT)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_LOOKUP-1:0][ID_SIZE-1:0]    IN_lookupIDs,
  output logic [NUM_LOOKUP-1:0]                 OUT_lookupAvail,
  output logic [NUM_LOOKUP-1:0][TAG_SIZE-1:0]   OUT_lookupSpecTag,
  input  logic [NUM_ISSUE-1:0]                  IN_issueValid,
  input  logic [NUM_ISSUE-1:0][ID_SIZE-1:0]     IN_issueIDs,
  input  logic [NUM_ISSUE-1:0][TAG_SIZE-1:0]    IN_issueTags,
  input  logic                                  IN_ckptSave,
  output logic [CKPT_ID-1:0]                    OUT_ckptID,
  output logic                                  OUT_ckptFull,
  input  logic                                  IN_ckptRelease,
  input  logic                                  IN_mispred,
  input  logic                                  IN_mispredCkptValid,
  input  logic [CKPT_ID-1:0]                    IN_mispredCkpt,
  input  logic [NUM_COMMIT-1:0]                 IN_commitValid,
  input  logic [NUM_COMMIT-1:0][ID_SIZE-1:0]    IN_commitIDs,
  input  logic [NUM_COMMIT-1:0][TAG_SIZE-1:0]   IN_commitTags,
  output logic [NUM_COMMIT-1:0][TAG_SIZE-1:0]   OUT_commitPrevTags,
  input  logic [NUM_WB-1:0]                     IN_wbValid,
  input  logic [NUM_WB-1:0][TAG_SIZE-1:0]       IN_wbTag
);

  localparam int unsigned NumTags = 1 << TAG_SIZE;

  logic [NUM_REGS-1:0][TAG_SIZE-1:0]               spec_q, spec_d, com_q, com_d, spec_issued;
  logic [NUM_CKPT-1:0][NUM_REGS-1:0][TAG_SIZE-1:0] snap_q, snap_d;
  logic [NumTags-1:0]                              ready_q, ready_d;
  logic [CKPT_ID-1:0]                              head_q, head_d, tail_q, tail_d, restore_cnt;
  logic [CKPT_ID:0]                                count_q, count_d;

  logic                  full, rel_ok, save_ok, save_drop, bad_release, wb_issue_clash;
  logic [NUM_LOOKUP-1:0] lk_byp;

  assign full         = (count_q == (CKPT_ID + 1)'(NUM_CKPT));
  assign rel_ok       = IN_ckptRelease && (count_q != '0);
  // A same-cycle release makes room, so a save while full is still accepted.
  assign save_ok      = IN_ckptSave && !IN_mispred && (!full || rel_ok);
  assign save_drop    = IN_ckptSave && !IN_mispred && full && !rel_ok;
  assign bad_release  = IN_mispred && IN_mispredCkptValid && rel_ok && (IN_mispredCkpt == head_q);
  assign OUT_ckptFull = full;
  assign OUT_ckptID   = tail_q;

  always_comb begin
    OUT_lookupSpecTag = '0;
    OUT_lookupAvail   = '0;
    lk_byp            = '0;
    for (int i = 0; i < NUM_LOOKUP; i++) begin
      OUT_lookupSpecTag[i] = spec_q[IN_lookupIDs[i]];
      // Only older slots of the same rename group can forward to this port.
      for (int j = 0; j < NUM_ISSUE; j++) begin
        if (j < i / 2 && IN_issueValid[j] && IN_issueIDs[j] != '0 &&
            IN_issueIDs[j] == IN_lookupIDs[i]) begin
          OUT_lookupSpecTag[i] = IN_issueTags[j];
          lk_byp[i]            = 1'b1;
        end
      end
      OUT_lookupAvail[i] = ready_q[OUT_lookupSpecTag[i]];
      for (int k = 0; k < NUM_WB; k++) begin
        if (IN_wbValid[k] && IN_wbTag[k] == OUT_lookupSpecTag[i]) OUT_lookupAvail[i] = 1'b1;
      end
      if (lk_byp[i]) OUT_lookupAvail[i] = 1'b0;
    end
  end

  always_comb begin
    OUT_commitPrevTags = '0;
    for (int c = 0; c < NUM_COMMIT; c++) OUT_commitPrevTags[c] = com_q[IN_commitIDs[c]];
  end

  always_comb begin
    wb_issue_clash = 1'b0;
    if (!IN_mispred) begin
      for (int j = 0; j < NUM_ISSUE; j++) begin
        for (int k = 0; k < NUM_WB; k++) begin
          if (IN_issueValid[j] && IN_issueIDs[j] != '0 && IN_wbValid[k] &&
              IN_wbTag[k] == IN_issueTags[j]) wb_issue_clash = 1'b1;
        end
      end
    end
  end

  always_comb begin
    spec_issued = spec_q;
    ready_d     = ready_q;
    com_d       = com_q;
    for (int j = 0; j < NUM_ISSUE; j++) begin
      if (IN_issueValid[j] && IN_issueIDs[j] != '0) begin
        spec_issued[IN_issueIDs[j]] = IN_issueTags[j];
        if (!IN_mispred) ready_d[IN_issueTags[j]] = 1'b0;
      end
    end
    // Writeback after the issue clear so it wins on a tag collision.
    for (int k = 0; k < NUM_WB; k++) begin
      if (IN_wbValid[k]) ready_d[IN_wbTag[k]] = 1'b1;
    end
    for (int c = 0; c < NUM_COMMIT; c++) begin
      if (IN_commitValid[c] && IN_commitIDs[c] != '0) com_d[IN_commitIDs[c]] = IN_commitTags[c];
    end
  end

  always_comb begin
    spec_d      = spec_q;
    snap_d      = snap_q;
    head_d      = head_q + CKPT_ID'(rel_ok);
    tail_d      = tail_q;
    count_d     = count_q;
    restore_cnt = IN_mispredCkpt - head_d;
    if (IN_mispred) begin
      if (IN_mispredCkptValid) begin
        spec_d  = snap_q[IN_mispredCkpt];
        tail_d  = IN_mispredCkpt;
        count_d = {1'b0, restore_cnt};
      end else begin
        spec_d  = com_d;
        head_d  = tail_q;
        count_d = '0;
      end
    end else begin
      spec_d = spec_issued;
      if (save_ok) begin
        snap_d[tail_q] = spec_issued;
        tail_d         = tail_q + CKPT_ID'(1);
      end
      count_d = count_q + (CKPT_ID + 1)'(save_ok) - (CKPT_ID + 1)'(rel_ok);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        spec_q[i] <= TAG_SIZE'(i);
        com_q[i]  <= TAG_SIZE'(i);
      end
      snap_q  <= '0;
      ready_q <= '1;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      spec_q  <= spec_d;
      com_q   <= com_d;
      snap_q  <= snap_d;
      ready_q <= ready_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  a_wb_issue_clash: assert property (@(posedge clk) disable iff (rst) !wb_issue_clash)
    else $error("writeback and issue of the same tag in one cycle");
  a_save_while_full: assert property (@(posedge clk) disable iff (rst) !save_drop)
    else $warning("checkpoint save dropped while full");
  a_release_restored: assert property (@(posedge clk) disable iff (rst) !bad_release)
    else $error("release of the checkpoint being restored");

endmodule

// File: tb/tb_rename_table_ckpt.sv
// Directed bench for rename_table_ckpt: lookup bypasses, checkpoint save/restore, full
// handling, committed-state recovery and asynchronous reset.
module tb_rename_table_ckpt;
  logic clk = 1'b0;
  logic rst;
  logic [3:0][4:0] lk_ids;
  logic [3:0]      lk_avail;
  logic [3:0][6:0] lk_tag;
  logic [1:0]      iss_v;
  logic [1:0][4:0] iss_ids;
  logic [1:0][6:0] iss_tags;
  logic            save, full, release_c, mispred, mp_valid;
  logic [1:0]      ckpt_id, mp_ckpt;
  logic [1:0]      cm_v;
  logic [1:0][4:0] cm_ids;
  logic [1:0][6:0] cm_tags, cm_prev;
  logic [3:0]      wb_v;
  logic [3:0][6:0] wb_tag;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rename_table_ckpt dut (
    .clk                (clk),
    .rst                (rst),
    .IN_lookupIDs       (lk_ids),
    .OUT_lookupAvail    (lk_avail),
    .OUT_lookupSpecTag  (lk_tag),
    .IN_issueValid      (iss_v),
    .IN_issueIDs        (iss_ids),
    .IN_issueTags       (iss_tags),
    .IN_ckptSave        (save),
    .OUT_ckptID         (ckpt_id),
    .OUT_ckptFull       (full),
    .IN_ckptRelease     (release_c),
    .IN_mispred         (mispred),
    .IN_mispredCkptValid(mp_valid),
    .IN_mispredCkpt     (mp_ckpt),
    .IN_commitValid     (cm_v),
    .IN_commitIDs       (cm_ids),
    .IN_commitTags      (cm_tags),
    .OUT_commitPrevTags (cm_prev),
    .IN_wbValid         (wb_v),
    .IN_wbTag           (wb_tag)
  );

  task automatic idle();
    lk_ids = '0; iss_v = '0; iss_ids = '0; iss_tags = '0; save = 0; release_c = 0;
    mispred = 0; mp_valid = 0; mp_ckpt = '0; cm_v = '0; cm_ids = '0; cm_tags = '0;
    wb_v = '0; wb_tag = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    lk_ids[0] = 5'd5; lk_ids[3] = 5'd31;
    #1;
    tests++; if (lk_tag[0] !== 7'd5) begin fails++; $display("FAIL reset_tag5 got %0d want 5", lk_tag[0]); end
    tests++; if (lk_avail[0] !== 1'b1) begin fails++; $display("FAIL reset_avail5 got %0b want 1", lk_avail[0]); end
    tests++; if (lk_tag[3] !== 7'd31) begin fails++; $display("FAIL reset_tag31 got %0d want 31", lk_tag[3]); end
    tests++; if (ckpt_id !== 2'd0) begin fails++; $display("FAIL reset_ckpt_id got %0d want 0", ckpt_id); end
    tests++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full got %0b want 0", full); end
  endtask

  task automatic test_issue_bypass();
    idle();
    iss_v[0] = 1; iss_ids[0] = 5'd3; iss_tags[0] = 7'd40; lk_ids[2] = 5'd3; lk_ids[0] = 5'd3;
    #1;
    tests++; if (lk_tag[2] !== 7'd40) begin fails++; $display("FAIL byp_tag got %0d want 40", lk_tag[2]); end
    tests++; if (lk_avail[2] !== 1'b0) begin fails++; $display("FAIL byp_avail got %0b want 0", lk_avail[2]); end
    tests++; if (lk_tag[0] !== 7'd3) begin fails++; $display("FAIL nobyp_port0 got %0d want 3", lk_tag[0]); end
    tick();
    idle(); lk_ids[0] = 5'd3;
    #1;
    tests++; if (lk_tag[0] !== 7'd40 || lk_avail[0] !== 1'b0) begin fails++; $display("FAIL issued_not_ready got tag %0d avail %0b want 40/0", lk_tag[0], lk_avail[0]); end
    wb_v[1] = 1; wb_tag[1] = 7'd40;
    #1;
    tests++; if (lk_avail[0] !== 1'b1) begin fails++; $display("FAIL wb_bypass got %0b want 1", lk_avail[0]); end
    tick();
    wb_v = '0;
    #1;
    tests++; if (lk_avail[0] !== 1'b1) begin fails++; $display("FAIL wb_ready got %0b want 1", lk_avail[0]); end
  endtask

  task automatic test_same_id_slots();
    idle();
    iss_v = 2'b11; iss_ids[0] = 5'd4; iss_tags[0] = 7'd20; iss_ids[1] = 5'd4; iss_tags[1] = 7'd21;
    lk_ids[3] = 5'd4; lk_ids[1] = 5'd4;
    #1;
    tests++; if (lk_tag[3] !== 7'd20 || lk_avail[3] !== 1'b0) begin fails++; $display("FAIL slot1_byp got tag %0d avail %0b want 20/0", lk_tag[3], lk_avail[3]); end
    tests++; if (lk_tag[1] !== 7'd4 || lk_avail[1] !== 1'b1) begin fails++; $display("FAIL slot0_nobyp got tag %0d avail %0b want 4/1", lk_tag[1], lk_avail[1]); end
    tick();
    idle(); lk_ids[0] = 5'd4;
    iss_v[0] = 1; iss_ids[0] = 5'd0; iss_tags[0] = 7'd30; lk_ids[2] = 5'd0;
    #1;
    tests++; if (lk_tag[0] !== 7'd21) begin fails++; $display("FAIL higher_slot_wins got %0d want 21", lk_tag[0]); end
    tests++; if (lk_tag[2] !== 7'd0 || lk_avail[2] !== 1'b1) begin fails++; $display("FAIL r0_no_byp got tag %0d avail %0b want 0/1", lk_tag[2], lk_avail[2]); end
    tick();
    idle(); lk_ids[0] = 5'd0;
    #1;
    tests++; if (lk_tag[0] !== 7'd0 || lk_avail[0] !== 1'b1) begin fails++; $display("FAIL r0_not_renamed got tag %0d avail %0b want 0/1", lk_tag[0], lk_avail[0]); end
  endtask

  task automatic test_mispred_restore();
    do_reset();
    iss_v[0] = 1; iss_ids[0] = 5'd3; iss_tags[0] = 7'd40; save = 1;
    tick();
    idle();
    tests++; if (ckpt_id !== 2'd1) begin fails++; $display("FAIL save_tail got %0d want 1", ckpt_id); end
    iss_v[0] = 1; iss_ids[0] = 5'd3; iss_tags[0] = 7'd41;
    tick();
    idle(); lk_ids[0] = 5'd3;
    #1;
    tests++; if (lk_tag[0] !== 7'd41) begin fails++; $display("FAIL spec_41 got %0d want 41", lk_tag[0]); end
    mispred = 1; mp_valid = 1; mp_ckpt = 2'd0;
    iss_v[0] = 1; iss_ids[0] = 5'd5; iss_tags[0] = 7'd45;
    tick();
    idle(); lk_ids[0] = 5'd3; lk_ids[1] = 5'd5;
    #1;
    tests++; if (lk_tag[0] !== 7'd40 || lk_avail[0] !== 1'b0) begin fails++; $display("FAIL restore_r3 got tag %0d avail %0b want 40/0", lk_tag[0], lk_avail[0]); end
    tests++; if (lk_tag[1] !== 7'd5) begin fails++; $display("FAIL issue_suppressed got %0d want 5", lk_tag[1]); end
    tests++; if (ckpt_id !== 2'd0 || full !== 1'b0) begin fails++; $display("FAIL restore_ptrs got id %0d full %0b want 0/0", ckpt_id, full); end
    // Expose ready[41] through a committed mapping restored by a non-checkpoint recovery.
    cm_v[0] = 1; cm_ids[0] = 5'd8; cm_tags[0] = 7'd41; mispred = 1;
    tick();
    idle(); lk_ids[0] = 5'd8;
    #1;
    tests++; if (lk_tag[0] !== 7'd41 || lk_avail[0] !== 1'b0) begin fails++; $display("FAIL ready41_kept got tag %0d avail %0b want 41/0", lk_tag[0], lk_avail[0]); end
  endtask

  task automatic test_ckpt_full();
    do_reset();
    release_c = 1;
    tick();
    idle(); save = 1;
    tick(); tick(); tick();
    tests++; if (ckpt_id !== 2'd3 || full !== 1'b0) begin fails++; $display("FAIL three_saves got id %0d full %0b want 3/0", ckpt_id, full); end
    tick();
    tests++; if (ckpt_id !== 2'd0 || full !== 1'b1) begin fails++; $display("FAIL four_saves got id %0d full %0b want 0/1", ckpt_id, full); end
    tick();
    tests++; if (ckpt_id !== 2'd0 || full !== 1'b1) begin fails++; $display("FAIL fifth_dropped got id %0d full %0b want 0/1", ckpt_id, full); end
    release_c = 1;
    tick();
    tests++; if (ckpt_id !== 2'd1 || full !== 1'b1) begin fails++; $display("FAIL rel_save_full got id %0d full %0b want 1/1", ckpt_id, full); end
    idle(); mispred = 1; mp_valid = 1; mp_ckpt = 2'd3;
    tick();
    tests++; if (ckpt_id !== 2'd3 || full !== 1'b0) begin fails++; $display("FAIL restore_ckpt3 got id %0d full %0b want 3/0", ckpt_id, full); end
    idle(); save = 1;
    tick();
    tests++; if (ckpt_id !== 2'd0 || full !== 1'b0) begin fails++; $display("FAIL count3 got id %0d full %0b want 0/0", ckpt_id, full); end
    tick();
    tests++; if (ckpt_id !== 2'd1 || full !== 1'b1) begin fails++; $display("FAIL count4 got id %0d full %0b want 1/1", ckpt_id, full); end
    idle();
  endtask

  task automatic test_commit_recover();
    do_reset();
    save = 1;
    tick(); tick();
    idle(); mispred = 1;
    cm_v = 2'b11; cm_ids[0] = 5'd7; cm_tags[0] = 7'd50; cm_ids[1] = 5'd9; cm_tags[1] = 7'd52;
    #1;
    tests++; if (cm_prev[0] !== 7'd7 || cm_prev[1] !== 7'd9) begin fails++; $display("FAIL prev_tags got %0d,%0d want 7,9", cm_prev[0], cm_prev[1]); end
    tick();
    idle(); lk_ids[0] = 5'd7; lk_ids[1] = 5'd9;
    #1;
    tests++; if (lk_tag[0] !== 7'd50 || lk_avail[0] !== 1'b1) begin fails++; $display("FAIL com_restore_r7 got tag %0d avail %0b want 50/1", lk_tag[0], lk_avail[0]); end
    tests++; if (lk_tag[1] !== 7'd52) begin fails++; $display("FAIL com_restore_r9 got %0d want 52", lk_tag[1]); end
    tests++; if (ckpt_id !== 2'd2 || full !== 1'b0) begin fails++; $display("FAIL com_ptrs got id %0d full %0b want 2/0", ckpt_id, full); end
    idle(); save = 1;
    tick(); tick(); tick();
    tests++; if (full !== 1'b0) begin fails++; $display("FAIL com_count3 got full %0b want 0", full); end
    tick();
    tests++; if (full !== 1'b1) begin fails++; $display("FAIL com_count4 got full %0b want 1", full); end
    idle(); mispred = 1;
    cm_v = 2'b11; cm_ids[0] = 5'd7; cm_tags[0] = 7'd60; cm_ids[1] = 5'd7; cm_tags[1] = 7'd61;
    #1;
    tests++; if (cm_prev[0] !== 7'd50 || cm_prev[1] !== 7'd50) begin fails++; $display("FAIL prev_after_commit got %0d,%0d want 50,50", cm_prev[0], cm_prev[1]); end
    tick();
    idle(); lk_ids[0] = 5'd7;
    #1;
    tests++; if (lk_tag[0] !== 7'd61 || full !== 1'b0) begin fails++; $display("FAIL commit_port_prio got tag %0d full %0b want 61/0", lk_tag[0], full); end
  endtask

  task automatic test_reset_mid_recovery();
    do_reset();
    iss_v[0] = 1; iss_ids[0] = 5'd9; iss_tags[0] = 7'd60; save = 1;
    tick();
    iss_v = '0;
    tick(); tick();
    idle(); mispred = 1; mp_valid = 1; mp_ckpt = 2'd1; lk_ids[0] = 5'd9;
    #1;
    tests++; if (ckpt_id !== 2'd3 || lk_tag[0] !== 7'd60) begin fails++; $display("FAIL pre_reset got id %0d tag %0d want 3/60", ckpt_id, lk_tag[0]); end
    #2;
    rst = 1'b1;
    #1;
    tests++; if (lk_tag[0] !== 7'd9 || lk_avail[0] !== 1'b1) begin fails++; $display("FAIL async_reset_map got tag %0d avail %0b want 9/1", lk_tag[0], lk_avail[0]); end
    tests++; if (ckpt_id !== 2'd0 || full !== 1'b0) begin fails++; $display("FAIL async_reset_ptrs got id %0d full %0b want 0/0", ckpt_id, full); end
    tick();
    rst = 1'b0;
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_issue_bypass();
    test_same_id_slots();
    test_mispred_restore();
    test_ckpt_full();
    test_commit_recover();
    test_reset_mid_recovery();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
